// File: rtl/spatial_sram_scheduler_if.sv
// ---------------------------------------------------------------------------
// spatial_sram_scheduler_if
//   Bundles the encoder-side, host-load-side and SRAM-control signals of the
//   spatial SRAM scheduler into one interface.
//   master : encoder/host/SRAM side (drives requests, observes SRAM controls)
//   slave  : the scheduler itself
//   Signals
//     EncAddr_DI   encoder channel address
//     EncReady_SI  per-modality encoder ready (bit0 = modality 1)
//     SramValid_SO per-modality data valid strobe
//     SramEn_SO    per-modality read enable
//     SramWe_SO    per-bank write enable, bit 3*mod+bank
//     SramAddr_DO  shared SRAM address
//     LoadValid_SI / LoadReady_SO  host write handshake
//     LoadMod_SI / LoadBank_SI / LoadAddr_DI  host write target
//     LoadErr_SO   pulse: accepted write was out of range and dropped
// ---------------------------------------------------------------------------
interface spatial_sram_scheduler_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] EncAddr_DI;
  logic [2:0]        EncReady_SI;
  logic [2:0]        SramValid_SO;
  logic [2:0]        SramEn_SO;
  logic [8:0]        SramWe_SO;
  logic [ADDR_W-1:0] SramAddr_DO;
  logic              LoadValid_SI;
  logic              LoadReady_SO;
  logic [1:0]        LoadMod_SI;
  logic [1:0]        LoadBank_SI;
  logic [ADDR_W-1:0] LoadAddr_DI;
  logic              LoadErr_SO;

  modport master (
    output EncAddr_DI, EncReady_SI, LoadValid_SI, LoadMod_SI, LoadBank_SI, LoadAddr_DI,
    input  SramValid_SO, SramEn_SO, SramWe_SO, SramAddr_DO, LoadReady_SO, LoadErr_SO
  );

  modport slave (
    input  EncAddr_DI, EncReady_SI, LoadValid_SI, LoadMod_SI, LoadBank_SI, LoadAddr_DI,
    output SramValid_SO, SramEn_SO, SramWe_SO, SramAddr_DO, LoadReady_SO, LoadErr_SO
  );
endinterface

// File: rtl/spatial_sram_scheduler.sv
// ---------------------------------------------------------------------------
// spatial_sram_scheduler
//   Sequences the nine item-memory / projection SRAM banks (iM, projM_neg,
//   projM_pos for modalities 1-3) feeding the spatial encoder. Converts the
//   encoder's channel address / per-modality ready into a read enable pulse,
//   waits the SRAM read latency, then raises per-modality data-valid while the
//   encoder stays on that address. A host load port writes bank rows between
//   reads and has priority over a new read when the scheduler is idle.
//   Ports
//     Clk_CI    clock
//     Reset_RI  synchronous active-high reset
//     bus       scheduler side of spatial_sram_scheduler_if (see interface)
// ---------------------------------------------------------------------------
module spatial_sram_scheduler #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2,
  parameter int DEPTH1 = 32,
  parameter int DEPTH2 = 109,
  parameter int DEPTH3 = 214
) (
  input  logic                      Clk_CI,
  input  logic                      Reset_RI,
  spatial_sram_scheduler_if.slave   bus
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_ISSUE,
    S_WAIT,
    S_VALID
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        mask_q, mask_d;
  logic [1:0]        lmod_q, lmod_d;
  logic [1:0]        lbank_q, lbank_d;
  logic [ADDR_W-1:0] laddr_q, laddr_d;

  logic [2:0]        enc_mask;
  logic [8:0]        we_onehot;
  logic [31:0]       load_depth;
  logic              load_legal;

  logic [2:0]        valid_o, en_o;
  logic [8:0]        we_o;
  logic [ADDR_W-1:0] addr_o;
  logic              ready_o, err_o;

  // Active mask: modality k takes part only if its encoder lane is ready and
  // the channel exists in its (shorter) bank; no wrap-around.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_mask
      localparam logic [31:0] DEP = (gi == 0) ? 32'(DEPTH1) :
                                    (gi == 1) ? 32'(DEPTH2) : 32'(DEPTH3);
      assign enc_mask[gi] = bus.EncReady_SI[gi] && (32'(bus.EncAddr_DI) < DEP);
    end
    for (gi = 0; gi < 9; gi++) begin : g_we
      assign we_onehot[gi] = (lmod_q == 2'(gi / 3)) && (lbank_q == 2'(gi % 3));
    end
  endgenerate

  always_comb begin
    load_depth = 32'd0;
    case (lmod_q)
      2'd0:    load_depth = 32'(DEPTH1);
      2'd1:    load_depth = 32'(DEPTH2);
      2'd2:    load_depth = 32'(DEPTH3);
      default: load_depth = 32'd0;
    endcase
  end

  assign load_legal = (lmod_q <= 2'd2) && (lbank_q <= 2'd2) && (32'(laddr_q) < load_depth);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    lmod_d  = lmod_q;
    lbank_d = lbank_q;
    laddr_d = laddr_q;
    valid_o = 3'b000;
    en_o    = 3'b000;
    we_o    = 9'h000;
    addr_o  = '0;
    ready_o = 1'b0;
    err_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (bus.LoadValid_SI) begin
          lmod_d  = bus.LoadMod_SI;
          lbank_d = bus.LoadBank_SI;
          laddr_d = bus.LoadAddr_DI;
          state_d = S_WRITE;
        end else if (enc_mask != 3'b000) begin
          addr_d  = bus.EncAddr_DI;
          mask_d  = enc_mask;
          state_d = S_ISSUE;
        end
      end

      S_WRITE: begin
        addr_o = laddr_q;
        if (load_legal) begin
          we_o = we_onehot;
        end else begin
          err_o = 1'b1;
        end
        state_d = S_IDLE;
      end

      S_ISSUE: begin
        en_o   = mask_q;
        addr_o = addr_q;
        // With single-cycle SRAMs the data is already there next cycle.
        if (RD_LAT == 1) begin
          state_d = S_VALID;
        end else begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        addr_o = addr_q;
        // WAIT spans RD_LAT-1 cycles, so the last one is when the count is 1.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_VALID;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_VALID: begin
        addr_o = addr_q;
        if (bus.EncAddr_DI == addr_q) begin
          valid_o = mask_q;
        end else if (!bus.LoadValid_SI && (enc_mask != 3'b000)) begin
          // Encoder moved on to another channel: chain straight into the next read.
          addr_d  = bus.EncAddr_DI;
          mask_d  = enc_mask;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are forced quiet in the reset cycle itself.
    if (Reset_RI) begin
      valid_o = 3'b000;
      en_o    = 3'b000;
      we_o    = 9'h000;
      addr_o  = '0;
      ready_o = 1'b0;
      err_o   = 1'b0;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      mask_q  <= 3'b000;
      lmod_q  <= 2'd0;
      lbank_q <= 2'd0;
      laddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      lmod_q  <= lmod_d;
      lbank_q <= lbank_d;
      laddr_q <= laddr_d;
    end
  end

  assign bus.SramValid_SO = valid_o;
  assign bus.SramEn_SO    = en_o;
  assign bus.SramWe_SO    = we_o;
  assign bus.SramAddr_DO  = addr_o;
  assign bus.LoadReady_SO = ready_o;
  assign bus.LoadErr_SO   = err_o;

endmodule

// File: tb/tb_spatial_sram_scheduler.sv
module tb_spatial_sram_scheduler;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  spatial_sram_scheduler_if #(.ADDR_W(8)) bus ();

  spatial_sram_scheduler #(
    .ADDR_W(8), .RD_LAT(2), .DEPTH1(32), .DEPTH2(109), .DEPTH3(214)
  ) dut (
    .Clk_CI   (clk),
    .Reset_RI (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Bring the scheduler back to IDLE with a bounded number of cycles.
  task automatic go_idle(input string tag);
    bus.LoadValid_SI = 1'b0;
    bus.EncReady_SI  = 3'b000;
    bus.EncAddr_DI   = 8'd255;
    settle();
    for (int i = 0; i < 8; i++) begin
      if (bus.LoadReady_SO) break;
      cyc();
    end
    check_val(tag, 32'(bus.LoadReady_SO), 32'd1);
  endtask

  // Read table: address with all lanes ready -> expected enable mask.
  typedef struct { logic [7:0] addr; logic [2:0] en; } rd_vec_t;
  rd_vec_t rd_tab [10] = '{
    '{8'd5,   3'b111}, '{8'd31,  3'b111}, '{8'd32,  3'b110}, '{8'd40,  3'b110},
    '{8'd108, 3'b110}, '{8'd109, 3'b100}, '{8'd200, 3'b100}, '{8'd213, 3'b100},
    '{8'd214, 3'b000}, '{8'd255, 3'b000}
  };

  // Load table: mod, bank, addr -> expected write enable and error pulse.
  typedef struct { logic [1:0] m; logic [1:0] b; logic [7:0] a; logic [8:0] we; logic err; } ld_vec_t;
  ld_vec_t ld_tab [7] = '{
    '{2'd0, 2'd2, 8'd31,  9'h004, 1'b0},
    '{2'd0, 2'd2, 8'd32,  9'h000, 1'b1},
    '{2'd2, 2'd2, 8'd213, 9'h100, 1'b0},
    '{2'd2, 2'd0, 8'd214, 9'h000, 1'b1},
    '{2'd1, 2'd1, 8'd108, 9'h010, 1'b0},
    '{2'd3, 2'd0, 8'd0,   9'h000, 1'b1},
    '{2'd1, 2'd3, 8'd0,   9'h000, 1'b1}
  };

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.EncAddr_DI   = 8'd0;
    bus.EncReady_SI  = 3'b000;
    bus.LoadValid_SI = 1'b0;
    bus.LoadMod_SI   = 2'd0;
    bus.LoadBank_SI  = 2'd0;
    bus.LoadAddr_DI  = 8'd0;

    // ---------------- reset ----------------
    cyc();
    cyc();
    check_val("rst_valid", 32'(bus.SramValid_SO), 32'd0);
    check_val("rst_en",    32'(bus.SramEn_SO),    32'd0);
    check_val("rst_we",    32'(bus.SramWe_SO),    32'd0);
    check_val("rst_addr",  32'(bus.SramAddr_DO),  32'd0);
    check_val("rst_ready", 32'(bus.LoadReady_SO), 32'd0);
    check_val("rst_err",   32'(bus.LoadErr_SO),   32'd0);
    rst = 1'b0;
    cyc();
    check_val("idle_ready", 32'(bus.LoadReady_SO), 32'd1);

    // ---------------- read addr 5, full timeline ----------------
    bus.EncAddr_DI  = 8'd5;
    bus.EncReady_SI = 3'b111;
    settle();
    check_val("rd5_T_en", 32'(bus.SramEn_SO), 32'd0);
    cyc();  // T+1 ISSUE
    check_val("rd5_T1_en",    32'(bus.SramEn_SO),    32'h7);
    check_val("rd5_T1_addr",  32'(bus.SramAddr_DO),  32'd5);
    check_val("rd5_T1_valid", 32'(bus.SramValid_SO), 32'd0);
    check_val("rd5_T1_ready", 32'(bus.LoadReady_SO), 32'd0);
    bus.EncReady_SI = 3'b001;  // ignored after the mask is latched
    cyc();  // T+2 WAIT
    check_val("rd5_T2_en",    32'(bus.SramEn_SO),    32'd0);
    check_val("rd5_T2_valid", 32'(bus.SramValid_SO), 32'd0);
    check_val("rd5_T2_addr",  32'(bus.SramAddr_DO),  32'd5);
    cyc();  // T+3 VALID
    check_val("rd5_T3_valid", 32'(bus.SramValid_SO), 32'h7);
    cyc();  // T+4 still on addr 5
    check_val("rd5_T4_valid", 32'(bus.SramValid_SO), 32'h7);
    bus.EncAddr_DI  = 8'd6;
    bus.EncReady_SI = 3'b111;
    settle();
    check_val("rd5_drop_valid", 32'(bus.SramValid_SO), 32'd0);
    cyc();  // chained ISSUE for addr 6
    check_val("rd6_chain_en",   32'(bus.SramEn_SO),   32'h7);
    check_val("rd6_chain_addr", 32'(bus.SramAddr_DO), 32'd6);
    go_idle("rd6_idle");

    // ---------------- partial ready ----------------
    bus.EncAddr_DI  = 8'd5;
    bus.EncReady_SI = 3'b010;
    settle();
    cyc();
    check_val("rd_partial_en", 32'(bus.SramEn_SO), 32'h2);
    go_idle("partial_idle");

    // ---------------- address boundary table ----------------
    foreach (rd_tab[i]) begin
      bus.EncAddr_DI  = rd_tab[i].addr;
      bus.EncReady_SI = 3'b111;
      settle();
      cyc();
      if (rd_tab[i].en != 3'b000) begin
        check_val($sformatf("rdtab_en_a%0d", rd_tab[i].addr), 32'(bus.SramEn_SO), 32'(rd_tab[i].en));
        check_val($sformatf("rdtab_addr_a%0d", rd_tab[i].addr), 32'(bus.SramAddr_DO), 32'(rd_tab[i].addr));
      end else begin
        check_val($sformatf("rdtab_noread_en_a%0d", rd_tab[i].addr), 32'(bus.SramEn_SO), 32'd0);
        check_val($sformatf("rdtab_noread_rdy_a%0d", rd_tab[i].addr), 32'(bus.LoadReady_SO), 32'd1);
      end
      go_idle($sformatf("rdtab_idle_a%0d", rd_tab[i].addr));
    end

    // ---------------- host loads ----------------
    foreach (ld_tab[i]) begin
      bus.LoadValid_SI = 1'b1;
      bus.LoadMod_SI   = ld_tab[i].m;
      bus.LoadBank_SI  = ld_tab[i].b;
      bus.LoadAddr_DI  = ld_tab[i].a;
      settle();
      check_val($sformatf("ld%0d_accept", i), 32'(bus.LoadReady_SO), 32'd1);
      cyc();  // WRITE
      bus.LoadValid_SI = 1'b0;
      settle();
      check_val($sformatf("ld%0d_we", i),    32'(bus.SramWe_SO),    32'(ld_tab[i].we));
      check_val($sformatf("ld%0d_err", i),   32'(bus.LoadErr_SO),   32'(ld_tab[i].err));
      check_val($sformatf("ld%0d_addr", i),  32'(bus.SramAddr_DO),  32'(ld_tab[i].a));
      check_val($sformatf("ld%0d_busy", i),  32'(bus.LoadReady_SO), 32'd0);
      cyc();  // back in IDLE
      check_val($sformatf("ld%0d_we_off", i),  32'(bus.SramWe_SO),  32'd0);
      check_val($sformatf("ld%0d_err_off", i), 32'(bus.LoadErr_SO), 32'd0);
    end
    go_idle("ld_idle");

    // ---------------- load beats read in the same IDLE cycle ----------------
    bus.LoadValid_SI = 1'b1;
    bus.LoadMod_SI   = 2'd1;
    bus.LoadBank_SI  = 2'd0;
    bus.LoadAddr_DI  = 8'd3;
    bus.EncAddr_DI   = 8'd5;
    bus.EncReady_SI  = 3'b111;
    settle();
    check_val("prio_accept", 32'(bus.LoadReady_SO), 32'd1);
    cyc();  // WRITE
    bus.LoadValid_SI = 1'b0;
    settle();
    check_val("prio_we", 32'(bus.SramWe_SO), 32'h008);
    check_val("prio_en_write", 32'(bus.SramEn_SO), 32'd0);
    cyc();  // IDLE
    check_val("prio_en_idle", 32'(bus.SramEn_SO), 32'd0);
    cyc();  // ISSUE
    check_val("prio_issue_en",   32'(bus.SramEn_SO),   32'h7);
    check_val("prio_issue_addr", 32'(bus.SramAddr_DO), 32'd5);
    go_idle("prio_idle");

    // ---------------- pending load while leaving VALID goes via IDLE ----------------
    bus.EncAddr_DI  = 8'd9;
    bus.EncReady_SI = 3'b111;
    settle();
    cyc();  // ISSUE
    cyc();  // WAIT
    cyc();  // VALID
    check_val("pend_valid", 32'(bus.SramValid_SO), 32'h7);
    bus.EncAddr_DI   = 8'd10;
    bus.LoadValid_SI = 1'b1;
    bus.LoadMod_SI   = 2'd0;
    bus.LoadBank_SI  = 2'd0;
    bus.LoadAddr_DI  = 8'd1;
    settle();
    check_val("pend_ready_in_valid", 32'(bus.LoadReady_SO), 32'd0);
    cyc();  // IDLE
    check_val("pend_idle_ready", 32'(bus.LoadReady_SO), 32'd1);
    check_val("pend_idle_en",    32'(bus.SramEn_SO),    32'd0);
    cyc();  // WRITE
    bus.LoadValid_SI = 1'b0;
    settle();
    check_val("pend_we", 32'(bus.SramWe_SO), 32'h001);
    go_idle("pend_idle");

    // ---------------- reset during WAIT ----------------
    bus.EncAddr_DI  = 8'd5;
    bus.EncReady_SI = 3'b111;
    settle();
    cyc();  // ISSUE
    cyc();  // WAIT
    rst = 1'b1;
    settle();
    check_val("rstw_en",    32'(bus.SramEn_SO),    32'd0);
    check_val("rstw_ready", 32'(bus.LoadReady_SO), 32'd0);
    cyc();
    rst = 1'b0;
    bus.EncReady_SI = 3'b000;
    settle();
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("rstw_novalid_%0d", i), 32'(bus.SramValid_SO), 32'd0);
      cyc();
    end
    bus.EncAddr_DI  = 8'd5;
    bus.EncReady_SI = 3'b111;
    settle();
    cyc();  // T+1
    check_val("rstw_re_en", 32'(bus.SramEn_SO), 32'h7);
    cyc();  // T+2
    check_val("rstw_re_wait_valid", 32'(bus.SramValid_SO), 32'd0);
    cyc();  // T+3
    check_val("rstw_re_valid", 32'(bus.SramValid_SO), 32'h7);
    go_idle("final_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
